c3d_rst_seq: RTL
================

// Module: c3d_rst_seq
// PURPOSE
//  Consumer side of the clock generator's PLL0_LOCK/PLL1_LOCK outputs and driver of the PLL RST inputs.
//  Pulses PLL reset, waits for both PLLs to lock stably, then releases domain resets in order.
//  Order: system/link domain first, memory (MCLK) domain second. On lock loss, re-asserts all resets and recovers.
//  Runs on the free-running input clock that feeds both PLLs, not on a PLL output.
// PARAMETERS
//  PLL_RST_CYC   16     cycles PLL_RST is held high per attempt (>=1)
//  LOCK_TIMEOUT  65535  cycles to wait for both locks before retrying (>=1)
//  STABLE_CYC    1024   cycles both locks must stay high before release (>=1)
//  REL_GAP       64     cycles between SYS_RST_N and MEM_RST_N release (>=1)
//  CNT_W         17     counter width; must hold max(all cycle params)
// PORTS
//  CLK            in   1   free-running reference clock (same net as PLL CLK_IN)
//  RST_N          in   1   synchronous active-low reset
//  PLL0_LOCK      in   1   PLL0 lock, asynchronous to CLK
//  PLL1_LOCK      in   1   PLL1 lock, asynchronous to CLK
//  PLL_RST        out  1   active-high reset to both PLLs
//  SYS_RST_N      out  1   active-low reset, PLL0 domains
//  MEM_RST_N      out  1   active-low reset, PLL1 domains
//  READY          out  1   sequence complete, both domains running
//  RETRY_CNT      out  8   lock-timeout retries, saturating at 255
//  LOSS_CNT       out  8   lock losses while in RUN, saturating at 255
// BEHAVIOUR
//  Lock sync: each LOCK passes a 2-flop synchronizer. lk = sync0 & sync1, 2-cycle latency. All decisions use lk.
//  Reset (RST_N=0 at edge): state=PLLRST, counter=0, PLL_RST=1, SYS_RST_N=0, MEM_RST_N=0, READY=0.
//    RST_N=0 also clears RETRY_CNT, LOSS_CNT and the synchronizers. It overrides everything, mid-sequence included.
//  FSM (one counter cnt, cleared on every state change):
//   PLLRST : PLL_RST=1. After PLL_RST_CYC cycles -> WAIT. PLL_RST is high exactly PLL_RST_CYC cycles.
//   WAIT   : PLL_RST=0. lk=1 -> STABLE.
//            If cnt reaches LOCK_TIMEOUT-1 with lk=0: -> PLLRST, RETRY_CNT+1 (saturating).
//   STABLE : lk=0 at any cycle -> WAIT (cnt restarts, no counter increment).
//            STABLE_CYC consecutive lk=1 cycles -> REL.
//   REL    : SYS_RST_N=1. After REL_GAP cycles -> RUN. lk=0 -> LOSS handling.
//   RUN    : SYS_RST_N=1, MEM_RST_N=1, READY=1. lk=0 -> LOSS handling.
//   LOSS handling: registered outputs next cycle SYS_RST_N=0, MEM_RST_N=0, READY=0.
//     State -> PLLRST. LOSS_CNT+1 (saturating) for loss in REL or RUN.
//  Outputs registered, decoded from next state. No glitches. MEM_RST_N never deasserts before SYS_RST_N.
//  Simultaneous events: lk drop on the same cycle as a timeout/stable/gap terminal count -> lk drop wins.
//  Counters saturate at 255 and never wrap.
// CONFIGURATION
//  C3D_RST_SWREQ_EN defined: adds input SW_RST_REQ (1 bit, sync to CLK).
//    SW_RST_REQ=1 in any state -> next cycle all resets asserted, READY=0, state=PLLRST.
//    RETRY_CNT and LOSS_CNT are unchanged. Held high -> stays in PLLRST with cnt held at 0.
//  Undefined: no SW_RST_REQ port. Sequence restarts only on RST_N or lock loss.
// TESTING (PLL_RST_CYC=4, LOCK_TIMEOUT=20, STABLE_CYC=8, REL_GAP=3)
//  1 Both locks rise 5 cycles after PLL_RST falls.
//    -> PLL_RST high 4 cycles; SYS_RST_N rises 2+8 cycles after lk; MEM_RST_N/READY rise 3 cycles later.
//  2 Locks held low -> PLL_RST re-pulses every 24 cycles; RETRY_CNT counts 1,2,3...; 300 attempts -> 255.
//  3 PLL1_LOCK drops 1 cycle at STABLE cnt=5 -> back to WAIT; full 8-cycle stable window required again.
//    SYS_RST_N stays 0; counters unchanged.
//  4 PLL0_LOCK drops in RUN -> SYS_RST_N=MEM_RST_N=READY=0 within 3 cycles; PLL_RST pulses 4; LOSS_CNT=1.
//  5 RST_N=0 for 1 cycle during REL -> all outputs at reset values next cycle, counters 0, sequence restarts.
//  6 SWREQ_EN: SW_RST_REQ pulse in RUN -> resets asserted next cycle; RETRY_CNT/LOSS_CNT unchanged; re-sequences.

Source files
------------

// File: rtl/c3d_rst_seq_if.sv
// PLL lock / domain-reset bundle between the reset sequencer and the clock generator side.
// Optional SW_RST_REQ input exists only when C3D_RST_SWREQ_EN is defined.
interface c3d_rst_seq_if;
    logic       pll0_lock;
    logic       pll1_lock;
`ifdef C3D_RST_SWREQ_EN
    logic       sw_rst_req;
`endif
    logic       pll_rst;
    logic       sys_rst_n;
    logic       mem_rst_n;
    logic       ready;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    // Sequencer side: consumes locks, drives resets and status
    modport master (
        input  pll0_lock,
        input  pll1_lock,
`ifdef C3D_RST_SWREQ_EN
        input  sw_rst_req,
`endif
        output pll_rst,
        output sys_rst_n,
        output mem_rst_n,
        output ready,
        output retry_cnt,
        output loss_cnt
    );

    // PLL / consumer side
    modport slave (
        output pll0_lock,
        output pll1_lock,
`ifdef C3D_RST_SWREQ_EN
        output sw_rst_req,
`endif
        input  pll_rst,
        input  sys_rst_n,
        input  mem_rst_n,
        input  ready,
        input  retry_cnt,
        input  loss_cnt
    );
endinterface

// File: rtl/c3d_rst_seq.sv
// PLL reset / lock-wait / ordered domain-release sequencer on the free-running reference clock.
// Optional feature macro: C3D_RST_SWREQ_EN (adds software restart request).
module c3d_rst_seq #(
    parameter int unsigned PLL_RST_CYC  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned STABLE_CYC   = 1024,
    parameter int unsigned REL_GAP      = 64,
    parameter int unsigned CNT_W        = 17
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    c3d_rst_seq_if.master  bus
);

    localparam int unsigned STAT_W = 8;

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_REL    = 3'd3,
        S_RUN    = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(REL_GAP - 1);
    localparam logic [STAT_W-1:0] STAT_MAX   = '1;

    logic [1:0]        sync0_q, sync1_q;
    logic              lk;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cnt_clr;
    logic [STAT_W-1:0] retry_q, retry_d;
    logic [STAT_W-1:0] loss_q, loss_d;
    logic              pll_rst_q, pll_rst_d;
    logic              sys_rst_n_q, sys_rst_n_d;
    logic              mem_rst_n_q, mem_rst_n_d;
    logic              ready_q, ready_d;

    // Two-flop synchronizers for the asynchronous lock inputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= {sync0_q[0], bus.pll0_lock};
            sync1_q <= {sync1_q[0], bus.pll1_lock};
        end
    end

    assign lk = sync0_q[1] & sync1_q[1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_PLLRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            mem_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            mem_rst_n_q <= mem_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    // Lock drop is tested before any terminal count so it always wins
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        unique case (state_q)
            S_PLLRST: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lk) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_PLLRST;
                    retry_d = (retry_q == STAT_MAX) ? retry_q : retry_q + STAT_W'(1);
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_d = S_WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!lk) begin
                    state_d = S_PLLRST;
                    loss_d  = (loss_q == STAT_MAX) ? loss_q : loss_q + STAT_W'(1);
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d = S_PLLRST;
                    loss_d  = (loss_q == STAT_MAX) ? loss_q : loss_q + STAT_W'(1);
                end
            end
            default: state_d = S_PLLRST;
        endcase

        cnt_clr = (state_d != state_q) || (state_q == S_RUN);

`ifdef C3D_RST_SWREQ_EN
        // Software restart overrides the sequence but leaves the statistics alone
        if (bus.sw_rst_req) begin
            state_d = S_PLLRST;
            retry_d = retry_q;
            loss_d  = loss_q;
            cnt_clr = 1'b1;
        end
`endif

        cnt_d = cnt_clr ? '0 : cnt_q + CNT_W'(1);

        pll_rst_d   = (state_d == S_PLLRST);
        sys_rst_n_d = (state_d == S_REL) || (state_d == S_RUN);
        mem_rst_n_d = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.mem_rst_n = mem_rst_n_q;
    assign bus.ready     = ready_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule
